// File: rtl/way_fill_demux.sv
// ---------------------------------------------------------------------------
// way_fill_demux
//
// Purpose:
//   This is the write-side partner of the L2 way-select read mux. It takes
//   one cache line from the memory fill bus as NBEATS narrow beats and builds
//   the full line in a local buffer. It then presents the line on a write-data
//   bus shared by all ways, with a single one-hot write enable that selects
//   the way chosen by the replacement logic.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   fill_start   request to begin a fill; only sampled while idle
//   fill_way     target way, latched when a fill starts
//   beat_valid   beat_data carries a valid beat
//   beat_data    one beat of fill data (beat 0 = least-significant slice)
//   beat_ready   beats are accepted this cycle (collect phase)
//   way_wr_en    one-hot way write enable, high only in the write cycle
//   way_wr_data  assembled line; consumers qualify it with way_wr_en
//   busy         high whenever a fill is in progress
//   fill_done    one-cycle pulse in the write cycle
//   fill_err     pulses with fill_done when the latched way does not exist
// ---------------------------------------------------------------------------
module way_fill_demux #(
  parameter int lineSize  = 512,
  parameter int ways      = 8,
  parameter int beatWidth = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fill_start,
  input  logic [$clog2(ways)-1:0]  fill_way,
  input  logic                     beat_valid,
  input  logic [beatWidth-1:0]     beat_data,
  output logic                     beat_ready,
  output logic [ways-1:0]          way_wr_en,
  output logic [lineSize-1:0]      way_wr_data,
  output logic                     busy,
  output logic                     fill_done,
  output logic                     fill_err
);

  localparam int NBEATS = lineSize / beatWidth;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int WW     = $clog2(ways);

  localparam logic [CW-1:0]   LAST_BEAT = CW'(NBEATS - 1);
  localparam logic [WW:0]     NUM_WAYS  = (WW + 1)'(ways);
  localparam logic [ways-1:0] ONE_WAY   = ways'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [WW-1:0]       way_q;
  logic [lineSize-1:0] line_q;
  logic                beat_ready_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [ways-1:0]     wr_en_q;

  logic [ways-1:0]     wr_en_d;
  logic                err_d;

  // Decode the latched way into the enable that the coming write cycle will
  // use. A way number past the last way can only happen when ways is not a
  // power of two. In that case no way is enabled and the fill is flagged as
  // an error.
  always_comb begin
    wr_en_d = '0;
    err_d   = 1'b0;
    if ({1'b0, way_q} < NUM_WAYS) begin
      wr_en_d = ONE_WAY << way_q;
    end else begin
      err_d = 1'b1;
    end
  end

  // Main fill FSM. All outputs are registered and change along with the
  // state, so they always match the current state. The write-cycle outputs
  // are loaded on the same edge that accepts the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      way_q        <= '0;
      line_q       <= '0;
      beat_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      wr_en_q      <= '0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_en_q <= '0;
      case (state_q)
        IDLE: begin
          if (fill_start) begin
            way_q        <= fill_way;
            cnt_q        <= '0;
            state_q      <= COLLECT;
            beat_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        COLLECT: begin
          if (beat_valid) begin
            // The slice written is chosen by the beat counter. The buffer is
            // never cleared between fills because every slice gets rewritten.
            for (int k = 0; k < NBEATS; k++) begin
              if (cnt_q == CW'(k)) begin
                line_q[k*beatWidth +: beatWidth] <= beat_data;
              end
            end
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST_BEAT) begin
              state_q      <= WRITE;
              beat_ready_q <= 1'b0;
              done_q       <= 1'b1;
              err_q        <= err_d;
              wr_en_q      <= wr_en_d;
            end
          end
        end
        WRITE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          beat_ready_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign beat_ready  = beat_ready_q;
  assign busy        = busy_q;
  assign fill_done   = done_q;
  assign fill_err    = err_q;
  assign way_wr_en   = wr_en_q;
  assign way_wr_data = line_q;

endmodule

// File: tb/tb_way_fill_demux.sv
// ---------------------------------------------------------------------------
// tb_way_fill_demux
//
// Drives two instances of way_fill_demux from the same inputs: one with
// 8 ways and one with 6 ways. Every fill is checked against a line-level
// model. The expected line is the plain concatenation of the beats sent.
// The expected enable is one-hot of the requested way, or nothing when that
// way does not exist in the instance.
// ---------------------------------------------------------------------------
module tb_way_fill_demux;

  localparam int NB = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fill_start;
  logic [2:0]   fill_way;
  logic         beat_valid;
  logic [63:0]  beat_data;

  logic         readyA, busyA, doneA, errA;
  logic [7:0]   enA;
  logic [511:0] dataA;
  logic         readyB, busyB, doneB, errB;
  logic [5:0]   enB;
  logic [511:0] dataB;

  way_fill_demux #(.lineSize(512), .ways(8), .beatWidth(64)) dutA (
    .clk(clk), .rst_n(rst_n), .fill_start(fill_start), .fill_way(fill_way),
    .beat_valid(beat_valid), .beat_data(beat_data), .beat_ready(readyA),
    .way_wr_en(enA), .way_wr_data(dataA), .busy(busyA),
    .fill_done(doneA), .fill_err(errA)
  );

  way_fill_demux #(.lineSize(512), .ways(6), .beatWidth(64)) dutB (
    .clk(clk), .rst_n(rst_n), .fill_start(fill_start), .fill_way(fill_way),
    .beat_valid(beat_valid), .beat_data(beat_data), .beat_ready(readyB),
    .way_wr_en(enB), .way_wr_data(dataB), .busy(busyB),
    .fill_done(doneB), .fill_err(errB)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nMis = 0;

  logic [63:0] beatPlan [NB];
  int          stallPlan[NB];

  int expDone = 0;
  int expErrB = 0;
  int seenDoneA = 0, seenDoneB = 0, seenErrA = 0, seenErrB = 0;
  int seenEnA = 0, seenEnB = 0;

  // Count every pulse seen on the write-side outputs. At the end these counts
  // are compared with the number of fills the bench completed.
  always @(negedge clk) begin
    if (doneA) seenDoneA++;
    if (doneB) seenDoneB++;
    if (errA)  seenErrA++;
    if (errB)  seenErrB++;
    if (|enA)  seenEnA++;
    if (|enB)  seenEnB++;
  end

  task automatic checkOutput(input string tag, input logic [511:0] obs,
                             input logic [511:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_readyA"}, 512'(readyA), 512'(0));
    checkOutput({tag, "_busyA"},  512'(busyA),  512'(0));
    checkOutput({tag, "_enA"},    512'(enA),    512'(0));
    checkOutput({tag, "_doneA"},  512'(doneA),  512'(0));
    checkOutput({tag, "_errA"},   512'(errA),   512'(0));
    checkOutput({tag, "_dataA"},  dataA,        512'(0));
    checkOutput({tag, "_busyB"},  512'(busyB),  512'(0));
    checkOutput({tag, "_enB"},    512'(enB),    512'(0));
    checkOutput({tag, "_dataB"},  dataB,        512'(0));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_readyA"}, 512'(readyA), 512'(0));
    checkOutput({tag, "_busyA"},  512'(busyA),  512'(0));
    checkOutput({tag, "_enA"},    512'(enA),    512'(0));
    checkOutput({tag, "_doneA"},  512'(doneA),  512'(0));
    checkOutput({tag, "_readyB"}, 512'(readyB), 512'(0));
    checkOutput({tag, "_busyB"},  512'(busyB),  512'(0));
    checkOutput({tag, "_enB"},    512'(enB),    512'(0));
  endtask

  task automatic checkCollect(input string tag);
    checkOutput({tag, "_readyA"}, 512'(readyA), 512'(1));
    checkOutput({tag, "_busyA"},  512'(busyA),  512'(1));
    checkOutput({tag, "_enA"},    512'(enA),    512'(0));
    checkOutput({tag, "_doneA"},  512'(doneA),  512'(0));
    checkOutput({tag, "_readyB"}, 512'(readyB), 512'(1));
    checkOutput({tag, "_enB"},    512'(enB),    512'(0));
  endtask

  // One complete fill. It is called in an IDLE cycle, away from the clock
  // edge, and returns at the falling edge of the first IDLE cycle after the
  // write. Beats come from beatPlan. stallPlan[k] idle cycles are inserted
  // before beat k. The poke flags drive fill_start with way 5 in the middle
  // of the collect phase and in the write cycle; both must be ignored.
  task automatic applyStimulus(input int way, input bit pokeCollect,
                               input bit pokeWrite);
    logic [511:0] expLine;
    logic [7:0]   expEnA;
    logic [5:0]   expEnB;
    for (int k = 0; k < NB; k++) expLine[k*64 +: 64] = beatPlan[k];
    expEnA = 8'(1) << way;
    expEnB = (way < 6) ? (6'(1) << way) : 6'(0);

    fill_start = 1'b1;
    fill_way   = 3'(way);
    @(posedge clk); #1;
    fill_start = 1'b0;
    fill_way   = 3'($urandom);

    for (int k = 0; k < NB; k++) begin
      for (int s = 0; s < stallPlan[k]; s++) begin
        beat_valid = 1'b0;
        beat_data  = {$urandom, $urandom};
        @(negedge clk);
        checkCollect("stall");
        @(posedge clk); #1;
      end
      beat_valid = 1'b1;
      beat_data  = beatPlan[k];
      if (pokeCollect && k == 3) begin
        fill_start = 1'b1;
        fill_way   = 3'd5;
      end
      @(negedge clk);
      checkCollect("beat");
      @(posedge clk); #1;
      fill_start = 1'b0;
    end
    beat_valid = 1'b0;
    beat_data  = {$urandom, $urandom};
    if (pokeWrite) begin
      fill_start = 1'b1;
      fill_way   = 3'd5;
    end

    @(negedge clk);
    checkOutput("wr_enA",   512'(enA),    512'(expEnA));
    checkOutput("wr_dataA", dataA,        expLine);
    checkOutput("doneA",    512'(doneA),  512'(1));
    checkOutput("errA",     512'(errA),   512'(0));
    checkOutput("wr_busyA", 512'(busyA),  512'(1));
    checkOutput("wr_rdyA",  512'(readyA), 512'(0));
    checkOutput("wr_enB",   512'(enB),    512'(expEnB));
    checkOutput("wr_dataB", dataB,        expLine);
    checkOutput("doneB",    512'(doneB),  512'(1));
    checkOutput("errB",     512'(errB),   512'(way >= 6));
    expDone++;
    if (way >= 6) expErrB++;

    @(posedge clk); #1;
    fill_start = 1'b0;
    @(negedge clk);
    checkIdle("post_wr");
    if (pokeWrite) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkIdle("no_refill");
    end
  endtask

  task automatic planBeats(input bit indexData, input int maxStall);
    for (int k = 0; k < NB; k++) begin
      beatPlan[k]  = indexData ? 64'(k) : {$urandom, $urandom};
      stallPlan[k] = (maxStall > 0) ? int'($urandom_range(0, maxStall)) : 0;
    end
  endtask

  // Starts a fill and sends beats 0..4. Reset is then asserted between clock
  // edges. The outputs must clear at once, and the aborted fill must never
  // produce a write.
  task automatic abortFill();
    planBeats(1'b0, 0);
    fill_start = 1'b1;
    fill_way   = 3'd6;
    @(posedge clk); #1;
    fill_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      beat_valid = 1'b1;
      beat_data  = beatPlan[k];
      @(posedge clk); #1;
    end
    beat_data = beatPlan[5];
    #1;
    rst_n = 1'b0;
    #2;
    checkAllZero("async_rst");
    @(negedge clk);
    beat_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checkIdle("after_abort");
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    fill_start = 1'b0;
    fill_way   = 3'd0;
    beat_valid = 1'b0;
    beat_data  = 64'd0;
    #3;
    checkAllZero("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    // beat_valid without a start must be ignored while idle
    beat_valid = 1'b1;
    beat_data  = 64'hDEAD_BEEF;
    @(negedge clk);
    checkIdle("idle");
    beat_valid = 1'b0;

    $display("[TB] basic fill to way 3");
    planBeats(1'b1, 0);
    applyStimulus(3, 1'b0, 1'b0);

    $display("[TB] stalled fill to way 3");
    planBeats(1'b1, 0);
    stallPlan[3] = 3;
    stallPlan[7] = 5;
    applyStimulus(3, 1'b0, 1'b0);

    $display("[TB] ignored starts during way 1 fill");
    planBeats(1'b0, 1);
    applyStimulus(1, 1'b1, 1'b1);

    $display("[TB] async reset mid fill");
    abortFill();
    planBeats(1'b0, 0);
    applyStimulus(0, 1'b0, 1'b0);

    $display("[TB] missing way on six-way instance");
    planBeats(1'b0, 1);
    applyStimulus(7, 1'b0, 1'b0);
    planBeats(1'b0, 0);
    applyStimulus(5, 1'b0, 1'b0);

    $display("[TB] back to back fills 0, 7, 0");
    planBeats(1'b0, 0);
    applyStimulus(0, 1'b0, 1'b0);
    planBeats(1'b0, 0);
    applyStimulus(7, 1'b0, 1'b0);
    planBeats(1'b0, 0);
    applyStimulus(0, 1'b0, 1'b0);

    $display("[TB] random fills");
    for (int i = 0; i < 12; i++) begin
      planBeats(1'b0, 2);
      applyStimulus(int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    checkOutput("cnt_doneA", 512'(seenDoneA), 512'(expDone));
    checkOutput("cnt_doneB", 512'(seenDoneB), 512'(expDone));
    checkOutput("cnt_errA",  512'(seenErrA),  512'(0));
    checkOutput("cnt_errB",  512'(seenErrB),  512'(expErrB));
    checkOutput("cnt_enA",   512'(seenEnA),   512'(expDone));
    checkOutput("cnt_enB",   512'(seenEnB),   512'(expDone - expErrB));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/way_fill_demux.md
Name: way_fill_demux

Overview:
- Write-side counterpart of the way-select read mux in the L2 data array.
- Collects one cache line from the memory-side fill bus in narrow beats and assembles it.
- Drives the assembled line onto a shared write-data bus with exactly one way write-enable asserted, so the line lands in the way chosen by the replacement logic.
- Sits between the memory fill interface and the per-way data RAM write ports.

Parameters:
- lineSize, 512, cache line width in bits.
- ways, 8, associativity (number of data ways); any value ≥ 2.
- beatWidth, 64, fill bus width in bits; lineSize must be an exact multiple of beatWidth.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- fill_start  input  1  request to begin a line fill; sampled only in IDLE.
- fill_way  input  $clog2(ways)  target way; latched on an accepted fill_start.
- beat_valid  input  1  beat_data is valid.
- beat_data  input  beatWidth  one fill beat.
- beat_ready  output  1  block accepts a beat this cycle.
- way_wr_en  output  ways  one-hot write enable, one bit per way.
- way_wr_data  output  lineSize  assembled line, common to all ways.
- busy  output  1  high whenever state is not IDLE.
- fill_done  output  1  one-cycle pulse marking the write cycle.
- fill_err  output  1  one-cycle pulse with fill_done when the latched way is ≥ ways.

Behaviour:
- Reset (async, rst_n=0): state = IDLE, beat counter = 0, latched way = 0, line buffer = 0.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - A partial fill in progress is discarded; no write is issued, during reset or after release.
- NBEATS = lineSize/beatWidth (8 by default). Beat counter width is $clog2(NBEATS), minimum 1.
- IDLE:
  - beat_ready = 0, busy = 0.
  - fill_start = 1 latches fill_way, clears the counter and moves to COLLECT.
  - beat_valid is ignored.
- COLLECT:
  - beat_ready = 1, busy = 1.
  - On each edge with beat_valid & beat_ready, beat_data is written into buffer bits [k*beatWidth +: beatWidth], where k = counter. Beat 0 is the least-significant slice.
  - The counter then increments.
  - On acceptance of beat NBEATS-1, the next state is WRITE. beat_ready stays high through that last-beat cycle.
  - Cycles with beat_valid = 0 stall without limit; there is no timeout.
  - fill_start is ignored.
- WRITE (exactly one cycle):
  - beat_ready = 0, busy = 1, fill_done = 1.
  - way_wr_data = buffer.
  - way_wr_en = one-hot of the latched way.
  - If latched way ≥ ways (possible only when ways is not a power of two): way_wr_en = 0 and fill_err = 1.
  - Next state is IDLE.
- Outside WRITE: way_wr_en = 0, fill_done = 0, fill_err = 0.
- way_wr_data holds the buffer contents in all states. Consumers qualify it with way_wr_en.
- Latency:
  - Start accepted at edge 0; first beat can be accepted at edge 1.
  - With back-to-back beats, the last beat is accepted at edge NBEATS.
  - WRITE is the cycle after edge NBEATS.
  - The earliest next fill_start is accepted at the edge that ends WRITE+1, i.e. the start must arrive in the IDLE cycle.
  - Start-to-write is NBEATS+1 cycles minimum.
- Simultaneous events:
  - fill_start asserted during WRITE is ignored; the requester must hold or re-issue it.
  - Changing fill_way after a start is accepted has no effect on the fill in progress.
- The buffer is not cleared between fills. Every slice is overwritten because all NBEATS beats are mandatory.

Test Plan:
- Basic fill: reset, start with fill_way=3, then 8 back-to-back beats 64'h0..07 (value = index).
  - way_wr_en = 8'b0000_1000 for exactly one cycle, 9 cycles after start.
  - way_wr_data[63:0] = 0, [511:448] = 7; fill_done pulses once.
- Stalled beats: same fill with beat_valid dropped for 3 cycles after beat 2 and 5 cycles after beat 6.
  - Identical way_wr_data; write occurs 8 cycles later than in the basic fill.
  - beat_ready stays high throughout COLLECT.
- Ignored starts: fill_start pulsed with fill_way=5 during COLLECT and again in the WRITE cycle of a way-1 fill.
  - Only way_wr_en = 8'b0000_0010 is seen.
  - busy falls for at least one cycle and no second fill begins.
- Async reset mid-fill: drop rst_n between clock edges after beat 4.
  - Outputs go to 0 before the next edge.
  - After release, no way_wr_en pulse ever occurs for the aborted fill.
  - A new full fill to way 0 writes correctly.
- Non-power-of-two ways=6: fill with fill_way=7.
  - way_wr_en = 0 for the whole fill; fill_done and fill_err both pulse.
  - A subsequent fill to way 5 gives way_wr_en = 6'b10_0000.
- Back-to-back fills to ways 0, 7, 0, each starting in the first IDLE cycle.
  - Each write carries only its own beat data and the correct one-hot enable.
  - Exactly 3 fill_done pulses.
